// File: rtl/ucie_protocol_arbiter.sv
// ucie_protocol_arbiter
//   Message-level arbiter sharing the D2D adapter TX path among
//   NUM_PROTOCOLS protocol-layer requesters. Grants are held for a whole
//   message. Per-protocol credits gate transmission, and age counters let
//   starved requesters override priority.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   protocol_enable     per-protocol enable
//   protocol_priority   4-bit priority per protocol (higher wins)
//   req_valid/req_last  requester flit valid / last flit of message
//   req_ready           flit accepted this cycle (owner only)
//   link_ready          adapter can take a flit
//   link_valid          flit presented to adapter
//   link_sel            owning protocol index (holds last owner when idle)
//   credit_return       one credit back per asserted cycle
//   credit_count        current credits per protocol
//   protocol_active     enable & credits available
//   credit_overflow     sticky: credit returned while already full
//   arb_busy            a message is in progress

// Per-protocol credit counter and age counter.
module ucie_protocol_arbiter_lane #(
  parameter int CREDIT_WIDTH = 8,
  parameter int INIT_CREDITS = 16,
  parameter int AGE_LIMIT    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    req_valid,
  input  logic                    credit_return,
  input  logic                    dec,      // owner transfer this cycle
  input  logic                    win,      // wins arbitration this cycle
  input  logic                    owned,    // current message owner
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    eligible,
  output logic                    starved,
  output logic                    active,
  output logic                    ovf_evt
);
  localparam logic [CREDIT_WIDTH-1:0] CMAX = CREDIT_WIDTH'(INIT_CREDITS);
  localparam logic [7:0]              ALIM = 8'(AGE_LIMIT);

  logic [7:0] age;
  logic       has_credit;

  assign has_credit = (credit_count != '0);
  assign eligible   = req_valid & enable & has_credit;
  assign starved    = eligible & (age >= ALIM);
  assign active     = enable & has_credit;
  // A return with a simultaneous decrement nets to zero, so only a lone
  // return at full credit is dropped.
  assign ovf_evt    = credit_return & ~dec & (credit_count == CMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_count <= CMAX;
      age          <= '0;
    end else begin
      if (dec && !credit_return)
        credit_count <= credit_count - 1'b1;
      else if (credit_return && !dec && credit_count != CMAX)
        credit_count <= credit_count + 1'b1;

      if (!eligible || win || owned)
        age <= '0;
      else if (age < ALIM)
        age <= age + 1'b1;
    end
  end
endmodule

module ucie_protocol_arbiter #(
  parameter int NUM_PROTOCOLS = 4,
  parameter int CREDIT_WIDTH  = 8,
  parameter int INIT_CREDITS  = 16,
  parameter int AGE_LIMIT     = 15,
  localparam int SW = (NUM_PROTOCOLS > 1) ? $clog2(NUM_PROTOCOLS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_PROTOCOLS-1:0]                   protocol_enable,
  input  logic [NUM_PROTOCOLS-1:0][3:0]              protocol_priority,
  input  logic [NUM_PROTOCOLS-1:0]                   req_valid,
  input  logic [NUM_PROTOCOLS-1:0]                   req_last,
  output logic [NUM_PROTOCOLS-1:0]                   req_ready,
  input  logic                                       link_ready,
  output logic                                       link_valid,
  output logic [SW-1:0]                              link_sel,
  input  logic [NUM_PROTOCOLS-1:0]                   credit_return,
  output logic [NUM_PROTOCOLS-1:0][CREDIT_WIDTH-1:0] credit_count,
  output logic [NUM_PROTOCOLS-1:0]                   protocol_active,
  output logic                                       credit_overflow,
  output logic                                       arb_busy
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]               state;
  logic [SW-1:0]            owner, rr_ptr, winner;
  logic [NUM_PROTOCOLS-1:0] eligible, starved, ovf_evt, cand;
  logic [NUM_PROTOCOLS-1:0] win_vec, dec_vec, own_vec;
  logic [3:0]               max_prio;
  logic                     any_elig, xfer, found;

  assign any_elig = |eligible;
  assign arb_busy = (state == LOCKED);
  assign link_sel = owner;
  assign xfer     = link_valid & link_ready;

  // Owner path: only registered state plus the owner's live handshake.
  always_comb begin
    link_valid = (state == LOCKED) & req_valid[owner] & (credit_count[owner] != '0);
    req_ready  = '0;
    req_ready[owner] = link_valid & link_ready;
  end

  // Winner: starved requesters first, else highest priority; ties and the
  // starved set resolve round-robin starting after rr_ptr.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_PROTOCOLS; i++)
      if (eligible[i] && protocol_priority[i] > max_prio)
        max_prio = protocol_priority[i];
    for (int i = 0; i < NUM_PROTOCOLS; i++)
      cand[i] = (|starved) ? starved[i]
                           : (eligible[i] && protocol_priority[i] == max_prio);
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 1; k <= NUM_PROTOCOLS; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_PROTOCOLS;
      if (!found && cand[idx]) begin
        winner = SW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROTOCOLS; i++) begin
      own_vec[i] = (state == LOCKED) && (owner == SW'(i));
      dec_vec[i] = xfer && (owner == SW'(i));
      win_vec[i] = (state == IDLE) && any_elig && (winner == SW'(i));
    end
  end

  for (genvar g = 0; g < NUM_PROTOCOLS; g++) begin : g_lane
    ucie_protocol_arbiter_lane #(
      .CREDIT_WIDTH (CREDIT_WIDTH),
      .INIT_CREDITS (INIT_CREDITS),
      .AGE_LIMIT    (AGE_LIMIT)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .enable        (protocol_enable[g]),
      .req_valid     (req_valid[g]),
      .credit_return (credit_return[g]),
      .dec           (dec_vec[g]),
      .win           (win_vec[g]),
      .owned         (own_vec[g]),
      .credit_count  (credit_count[g]),
      .eligible      (eligible[g]),
      .starved       (starved[g]),
      .active        (protocol_active[g]),
      .ovf_evt       (ovf_evt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= SW'(NUM_PROTOCOLS - 1);
      credit_overflow <= 1'b0;
    end else begin
      if (|ovf_evt) credit_overflow <= 1'b1;
      case (state)
        IDLE: if (any_elig) begin
          owner <= winner;
          state <= LOCKED;
        end
        default: if (xfer && req_last[owner]) begin
          // Enable changes are ignored here: the message always completes.
          state  <= IDLE;
          rr_ptr <= owner;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ucie_protocol_arbiter.sv
module tb_ucie_protocol_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     protocol_enable = '1;
  logic [N-1:0][3:0] protocol_priority = '0;
  logic [N-1:0]     req_valid = '0, req_last = '0, req_ready;
  logic             link_ready = 1'b1, link_valid;
  logic [1:0]       link_sel;
  logic [N-1:0]     credit_return = '0;
  logic [N-1:0][7:0] credit_count;
  logic [N-1:0]     protocol_active;
  logic             credit_overflow, arb_busy;

  ucie_protocol_arbiter #(.NUM_PROTOCOLS(N)) dut (
    .clk(clk), .rst(rst), .protocol_enable(protocol_enable),
    .protocol_priority(protocol_priority), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .link_ready(link_ready),
    .link_valid(link_valid), .link_sel(link_sel),
    .credit_return(credit_return), .credit_count(credit_count),
    .protocol_active(protocol_active), .credit_overflow(credit_overflow),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int msgs[N], len[N], fl[N], xc[N];
  int q[$];
  bit sb_on = 0, prev_last = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester model: msgs[i] messages of len[i] flits each.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = msgs[i] > 0;
      req_last[i]  = (fl[i] == len[i] - 1);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      msgs[i] = 0; fl[i] = 0; len[i] = 1; xc[i] = 0;
    end
    q.delete();
    prev_last = 0;
    drive();
  endtask

  // One cycle: sample at negedge (scoreboard), advance model after posedge.
  task automatic tick();
    logic [N-1:0] acc;
    int exp;
    @(negedge clk);
    acc = req_ready;
    if (prev_last) chk("bubble_idle", {30'd0, link_valid, arb_busy}, 0);
    prev_last = 0;
    if (link_valid && link_ready) begin
      xc[link_sel]++;
      if (sb_on) begin
        if (q.size() == 0) chk("sb_underflow", q.size(), 1);
        else begin
          exp = q.pop_front();
          chk("sb_owner", link_sel, exp);
        end
      end
      if (req_last[link_sel]) prev_last = 1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        if (fl[i] == len[i] - 1) begin fl[i] = 0; msgs[i]--; end
        else fl[i]++;
      end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit, required $finish first");
    $fatal(1);
  end

  initial begin
    flush();
    // Reset state
    do_reset();
    for (int i = 0; i < N; i++) chk("rst_credit", credit_count[i], 16);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_active", protocol_active, 4'b1111);
    chk("rst_ovf", credit_overflow, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_sel", link_sel, 0);

    // Priority with round-robin tie break
    protocol_priority[0] = 4'd2; protocol_priority[1] = 4'd9;
    protocol_priority[2] = 4'd9; protocol_priority[3] = 4'd5;
    for (int i = 0; i < N; i++) begin msgs[i] = 1; len[i] = 3; end
    foreach (q[i]) ;
    for (int k = 0; k < 3; k++) q.push_back(1);
    for (int k = 0; k < 3; k++) q.push_back(2);
    for (int k = 0; k < 3; k++) q.push_back(3);
    for (int k = 0; k < 3; k++) q.push_back(0);
    sb_on = 1;
    drive();
    for (int c = 0; c < 20; c++) tick();
    chk("prio_sb_empty", q.size(), 0);
    for (int i = 0; i < N; i++) chk("prio_xfers", xc[i], 3);
    chk("prio_credit1", credit_count[1], 13);

    // Starvation: low-priority P0 against back-to-back P1
    do_reset();
    sb_on = 0;
    protocol_priority = '0;
    protocol_priority[0] = 4'd1; protocol_priority[1] = 4'd15;
    msgs[0] = 1;   len[0] = 1;
    msgs[1] = 100; len[1] = 1;
    drive();
    for (int c = 0; c < 60 && xc[0] == 0; c++) tick();
    chk("starve_p0_granted", xc[0], 1);
    chk("starve_p1_before", xc[1], 8);
    chk("starve_bound", xc[1] <= 16, 1);

    // Credits exhaust and a single return
    do_reset();
    sb_on = 1;
    msgs[2] = 1; len[2] = 20;
    for (int k = 0; k < 16; k++) q.push_back(2);
    drive();
    for (int c = 0; c < 25; c++) tick();
    chk("cred_xfers16", xc[2], 16);
    chk("cred_stall_valid", link_valid, 0);
    chk("cred_active2", protocol_active[2], 0);
    chk("cred_zero", credit_count[2], 0);
    chk("cred_busy", arb_busy, 1);
    q.push_back(2);
    credit_return[2] = 1'b1; tick(); credit_return[2] = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("cred_xfers17", xc[2], 17);
    chk("cred_sb_empty", q.size(), 0);
    chk("cred_zero_again", credit_count[2], 0);
    sb_on = 0;

    // Reset while stalled mid-message
    do_reset();
    chk("rst_mid_busy", arb_busy, 0);
    chk("rst_mid_credit2", credit_count[2], 16);

    // Transfer plus return on owner in the same cycle
    msgs[0] = 1; len[0] = 8;
    drive();
    tick(); tick(); tick();
    chk("simul_pre", credit_count[0], 14);
    credit_return[0] = 1'b1;
    tick(); tick(); tick();
    credit_return[0] = 1'b0;
    chk("simul_xfers", xc[0], 5);
    chk("simul_count", credit_count[0], 14);
    chk("simul_no_ovf", credit_overflow, 0);
    // Reset while actively transferring
    rst = 1'b1; tick();
    chk("rst_xfer_busy", arb_busy, 0);
    chk("rst_xfer_valid", link_valid, 0);
    chk("rst_xfer_credit", credit_count[0], 16);
    rst = 1'b0;
    flush();

    // Overflow on a full counter, sticky until reset
    credit_return[3] = 1'b1; tick(); credit_return[3] = 1'b0;
    chk("ovf_count", credit_count[3], 16);
    chk("ovf_set", credit_overflow, 1);
    tick(); tick(); tick();
    chk("ovf_sticky", credit_overflow, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_cleared", credit_overflow, 0);
    flush();

    // Enable dropped on owner mid-message, with a link stall
    do_reset();
    sb_on = 1;
    msgs[1] = 1; len[1] = 3;
    for (int k = 0; k < 3; k++) q.push_back(1);
    drive();
    tick(); tick();
    protocol_enable[1] = 1'b0;
    link_ready = 1'b0;
    tick();
    chk("stall_valid", link_valid, 1);
    chk("stall_ready", req_ready, 0);
    link_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("en_drop_xfers", xc[1], 3);
    chk("en_drop_sb_empty", q.size(), 0);
    chk("en_drop_idle", arb_busy, 0);
    chk("en_drop_active", protocol_active[1], 0);
    protocol_enable = '1;
    sb_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ucie_protocol_arbiter.md
# ucie_protocol_arbiter

Message-level arbiter that shares the single D2D adapter transmit path among up to NUM_PROTOCOLS protocol-layer requesters (PCIe, CXL, streaming, management). It sits between the protocol-layer TX queues and the D2D adapter. It runs on the per-protocol enable and 4-bit priority fields of the configuration interface and reports which protocols are active. It enforces per-protocol transmit credits, holds a grant for a whole message, and ages starved requesters so none is locked out.

## Interface
- NUM_PROTOCOLS, 4, number of requesters (2..8)
- CREDIT_WIDTH, 8, width of each credit counter
- INIT_CREDITS, 16, credit count loaded at reset, also the saturation maximum (≤ 2^CREDIT_WIDTH−1)
- AGE_LIMIT, 15, wait cycles after which a requester is treated as starved (≤ 255)

- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- protocol_enable  in  NUM_PROTOCOLS  per-protocol enable
- protocol_priority  in  NUM_PROTOCOLS×4  priority per protocol, higher value wins
- req_valid  in  NUM_PROTOCOLS  requester has a flit
- req_last  in  NUM_PROTOCOLS  flit is last of its message
- req_ready  out  NUM_PROTOCOLS  flit accepted this cycle
- link_ready  in  1  D2D adapter can accept a flit
- link_valid  out  1  flit presented to adapter
- link_sel  out  $clog2(NUM_PROTOCOLS)  index of the owning protocol (mux select)
- credit_return  in  NUM_PROTOCOLS  one credit returned per cycle asserted
- credit_count  out  NUM_PROTOCOLS×CREDIT_WIDTH  current credits
- protocol_active  out  NUM_PROTOCOLS  enable[i] & (credit_count[i] != 0)
- credit_overflow  out  1  sticky: return received while at INIT_CREDITS
- arb_busy  out  1  state == LOCKED

## Operation
- Eligible[i] = req_valid[i] & protocol_enable[i] & (credit_count[i] != 0).
- FSM has 2 states.
  - IDLE: if any requester is eligible, pick a winner, register owner ← winner, go to LOCKED. Otherwise stay in IDLE.
  - LOCKED: owner is fixed. A transfer is link_valid & link_ready. A transfer with req_last[owner] returns the FSM to IDLE and sets rr_ptr ← owner.
- Winner selection, in this order:
  - If any eligible requester has age ≥ AGE_LIMIT, choose among those starved requesters only, round-robin.
  - Otherwise take the highest protocol_priority. Break ties round-robin.
  - Round-robin order starts at rr_ptr+1 and wraps modulo NUM_PROTOCOLS.
- In LOCKED:
  - link_valid = req_valid[owner] & (credit_count[owner] != 0)
  - req_ready[owner] = link_valid & link_ready
  - req_ready is 0 for all other requesters.
  - link_sel = owner. In IDLE, link_sel holds the last owner.
- Disabling the owner mid-message has no effect until req_last completes: message atomicity takes precedence.
- Credits:
  - Each transfer decrements credit_count[owner] by 1.
  - credit_return[i] increments credit_count[i] by 1.
  - Decrement and return in the same cycle leave the count unchanged.
  - A return at INIT_CREDITS with no simultaneous decrement is dropped and sets credit_overflow.
  - At 0 credits the owner stalls in LOCKED (link_valid=0) until a credit returns.
- Age counters: one 8-bit counter per protocol.
  - Increments (saturating at AGE_LIMIT) each cycle the protocol is eligible and not being granted/owner.
  - Clears when it wins arbitration or when it is not eligible.

## Timing
- Reset values:
  - state IDLE, owner 0, rr_ptr NUM_PROTOCOLS−1, link_sel 0
  - all credit_count = INIT_CREDITS, ages 0
  - credit_overflow 0, arb_busy 0, link_valid 0, req_ready 0
  - protocol_active = protocol_enable
- rst asserted mid-message aborts the message and restores all reset values on the next edge.
- Arbitration latency:
  - Eligible in IDLE at cycle t → LOCKED at t+1; the first flit can be accepted at t+1.
  - Back-to-back messages cost one IDLE bubble cycle.
- link_valid and req_ready are combinational from req_valid, link_ready and registered state. There is no combinational path from req_valid to the owner selection.
- credit_count and protocol_active update on the edge after the transfer or return.
- A single-flit message (req_last with the first flit): transfer at t+1, IDLE at t+2.

## Test plan
- Reset: rst high for 2 cycles with enables 4'b1111 → credit_count all 16, link_valid=0, arb_busy=0, protocol_active=4'b1111, credit_overflow=0.
- Priority: priorities {P0=2, P1=9, P2=9, P3=5}, all requesting 3-flit messages after reset → grant order P1, P2, P3, P0. Each grant holds exactly 3 transfers, with one IDLE cycle between messages.
- Starvation: P0 priority 1 requests continuously while P1 (priority 15) sends back-to-back 1-flit messages → P0 is granted within AGE_LIMIT+2 arbitrations.
- Credits: INIT_CREDITS=16, P2 sends a 20-flit message with no returns → 16 transfers, then link_valid=0 and protocol_active[2]=0. A single credit_return[2] pulse → exactly one more transfer.
- Simultaneous events:
  - Transfer and credit_return on the owner in the same cycle → count unchanged.
  - credit_return on P3 at 16 credits → count stays 16, credit_overflow=1 and stays 1 until rst.
- Mid-operation: protocol_enable[owner] dropped mid-message → message completes. rst mid-message → state IDLE and credits 16 on the next edge.
